fc_classifier: RTL and testbench
================================

FC_CLASSIFIER -- requirements
Module: fc_classifier

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH 8, activation/weight width, signed; IN_LEN 7168, pooled vector length (32x14x16); NUM_CLASSES 8, gesture classes; BIAS_WIDTH 32, signed bias width; ACC_WIDTH 32, accumulator width; ACT_ADDR_WIDTH 13; WGT_ADDR_WIDTH 16; CLS_WIDTH 3.
REQ-002 Ports SHALL be, in this order:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin one classification.
- busy, out, 1, high from start acceptance until done.
- act_addr, out, ACT_ADDR_WIDTH, pooled-activation BRAM address.
- act_data, in, DATA_WIDTH, pooled-activation BRAM read data.
- wgt_addr, out, WGT_ADDR_WIDTH, weight BRAM address.
- wgt_data, in, DATA_WIDTH, weight BRAM read data.
- bias_addr, out, CLS_WIDTH, bias ROM address.
- bias_data, in, BIAS_WIDTH, bias ROM read data.
- logit_valid, out, 1, one-cycle strobe per finished class.
- logit_idx, out, CLS_WIDTH, class index of logit_out.
- logit_out, out, ACC_WIDTH, signed class score.
- class_id, out, CLS_WIDTH, argmax result.
- done, out, 1, one-cycle completion pulse.

Function
REQ-003 All memories SHALL have a read latency of 2 cycles: an address driven in cycle t returns data sampled in cycle t+2.
REQ-004 States SHALL be IDLE, BIAS, MAC, DRAIN, EMIT and FIN.
REQ-005 IDLE SHALL go to BIAS when start=1; start SHALL be ignored in every other state.
REQ-006 BIAS SHALL last 3 cycles:
- Cycle 0 drives bias_addr=k (k is the current class).
- Cycle 2 loads acc with bias_data sign-extended to ACC_WIDTH.
- The state then goes to MAC.
REQ-007 MAC SHALL last IN_LEN cycles; cycle i drives act_addr=i and wgt_addr=k*IN_LEN+i.
REQ-008 A 2-stage valid shift register SHALL track the issued addresses; each returning pair SHALL add sign-extended act_data*wgt_data (full 2*DATA_WIDTH signed product) to acc.
REQ-009 Accumulation SHALL wrap modulo 2^ACC_WIDTH; no saturation.
REQ-010 DRAIN SHALL last 2 cycles and accumulate the last two products, then go to EMIT.
REQ-011 EMIT (1 cycle) SHALL register logit_out=acc and logit_idx=k, with logit_valid=1 in the following cycle.
REQ-012 EMIT SHALL update the running maximum:
- k=0 always loads max and best.
- k>0 loads only when acc is strictly greater than max (signed compare), so ties keep the lower index.
REQ-013 After EMIT the block SHALL go to BIAS with k+1 if k<NUM_CLASSES-1, otherwise to FIN.
REQ-014 FIN SHALL last 1 cycle, drive class_id=best and done=1 in the following cycle, and return to IDLE.
REQ-015 Cycles per class SHALL be IN_LEN+6; done SHALL rise NUM_CLASSES*(IN_LEN+6)+2 cycles after the cycle start is sampled.
REQ-016 busy SHALL be high in every state except IDLE; done and logit_valid SHALL each be single-cycle pulses.
REQ-017 class_id and logit_out SHALL hold their last values until the next classification overwrites them.
REQ-018 A start asserted in the same cycle as done SHALL be ignored; a new start is accepted only in IDLE.
REQ-019 Address outputs SHALL hold their last value outside MAC and BIAS.

Reset
REQ-020 When rst_n=0, the following SHALL clear asynchronously: state to IDLE, and k, acc, max, best, the valid pipe, all addresses, logit_out, logit_idx, class_id, logit_valid, done and busy all to 0.
REQ-021 Reset asserted mid-classification SHALL abort with no logit_valid or done pulse; the block SHALL restart only on a fresh start.

Structure
REQ-022 Package fc_pkg SHALL hold the state enum fc_state_t and the default constants IN_LEN, NUM_CLASSES and ACC_WIDTH.
REQ-023 The multiply/valid pipeline SHALL be sub-module fc_mac (inputs: product operands and issue strobe; outputs: sign-extended product and valid); the FSM, accumulator and argmax SHALL stay in fc_classifier.

Verification
REQ-024 The bench SHALL use IN_LEN=4, NUM_CLASSES=3 and behavioural 2-cycle memories, and cover:
- Scenario 1 (basic): act={1,2,3,4}, weights class0={1,1,1,1}, class1={0,0,0,2}, class2={-1,0,0,0}, biases={0,5,100} -> logits 10, 13, 99; class_id=2; done at cycle 3*(4+6)+2=32 after start.
- Scenario 2 (negatives): act={-128,-128,-128,-128}, weights class0 all -128, others 0, biases 0 -> logit0=65536, class_id=0.
- Scenario 3 (tie): all weights 0, biases={7,7,3} -> class_id=0.
- Scenario 4 (abort): rst_n pulsed low in MAC of class 1 -> no done pulse, all outputs 0; a fresh start then completes normally with the Scenario 1 result.
- Scenario 5 (start while busy): start held high throughout -> exactly one classification per IDLE entry; done pulses 1 cycle; no start accepted in the done cycle.
- Scenario 6 (all-negative logits): biases={-10,-3,-20}, weights 0 -> class_id=1 (signed compare).

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and default sizes for the FC classifier.
// Holds the FSM state enum and the default vector/class/accumulator sizes.
package fc_pkg;

  localparam int IN_LEN      = 7168;
  localparam int NUM_CLASSES = 8;
  localparam int ACC_WIDTH   = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_MAC,
    S_DRAIN,
    S_EMIT,
    S_FIN
  } fc_state_t;

endpackage

// File: rtl/fc_mac.sv
// Multiply stage: signed operand product plus a 2-deep issue/valid pipe.
// Ports: clk, rst_n, issue, act, wgt -> prod (sign-extended), valid.
module fc_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue,
  input  logic [DATA_WIDTH-1:0] act,
  input  logic [DATA_WIDTH-1:0] wgt,
  output logic [ACC_WIDTH-1:0]  prod,
  output logic                  valid
);

  logic [1:0] vpipe;
  logic signed [2*DATA_WIDTH-1:0] p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
    end else begin
      vpipe <= {vpipe[0], issue};
    end
  end

  // Operands arrive two cycles after their address, in step with vpipe[1].
  assign p     = $signed(act) * $signed(wgt);
  assign prod  = ACC_WIDTH'(p);
  assign valid = vpipe[1];

endmodule

// File: rtl/fc_classifier.sv
// Fully-connected classifier: per-class bias + dot product, then argmax.
// Ports: start/busy/done handshake, act/wgt/bias memory ports, logit stream, class_id.
module fc_classifier #(
  parameter int DATA_WIDTH     = 8,
  parameter int IN_LEN         = fc_pkg::IN_LEN,
  parameter int NUM_CLASSES    = fc_pkg::NUM_CLASSES,
  parameter int BIAS_WIDTH     = 32,
  parameter int ACC_WIDTH      = fc_pkg::ACC_WIDTH,
  parameter int ACT_ADDR_WIDTH = 13,
  parameter int WGT_ADDR_WIDTH = 16,
  parameter int CLS_WIDTH      = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic [ACT_ADDR_WIDTH-1:0] act_addr,
  input  logic [DATA_WIDTH-1:0]     act_data,
  output logic [WGT_ADDR_WIDTH-1:0] wgt_addr,
  input  logic [DATA_WIDTH-1:0]     wgt_data,
  output logic [CLS_WIDTH-1:0]      bias_addr,
  input  logic [BIAS_WIDTH-1:0]     bias_data,
  output logic                      logit_valid,
  output logic [CLS_WIDTH-1:0]      logit_idx,
  output logic [ACC_WIDTH-1:0]      logit_out,
  output logic [CLS_WIDTH-1:0]      class_id,
  output logic                      done
);

  import fc_pkg::*;

  localparam logic [ACT_ADDR_WIDTH-1:0] BIAS_LAST  = ACT_ADDR_WIDTH'(2);
  localparam logic [ACT_ADDR_WIDTH-1:0] MAC_LAST   = ACT_ADDR_WIDTH'(IN_LEN - 1);
  localparam logic [ACT_ADDR_WIDTH-1:0] DRAIN_LAST = ACT_ADDR_WIDTH'(1);
  localparam logic [CLS_WIDTH-1:0]      K_LAST     = CLS_WIDTH'(NUM_CLASSES - 1);

  fc_state_t state, state_n;
  logic [ACT_ADDR_WIDTH-1:0] cnt, cnt_n;
  logic [CLS_WIDTH-1:0]      k, k_n;
  logic [ACC_WIDTH-1:0]      acc;
  logic [ACC_WIDTH-1:0]      max_q;
  logic [CLS_WIDTH-1:0]      best;
  logic [ACC_WIDTH-1:0]      mac_prod;
  logic                      mac_valid;
  logic                      issue;

  assign issue = (state == S_MAC);
  assign busy  = (state != S_IDLE);

  fc_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .issue (issue),
    .act   (act_data),
    .wgt   (wgt_data),
    .prod  (mac_prod),
    .valid (mac_valid)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    k_n     = k;
    unique case (state)
      S_IDLE: begin
        // done is high only in the first IDLE cycle; a start there is dropped.
        if (start && !done) begin
          state_n = S_BIAS;
          cnt_n   = '0;
          k_n     = '0;
        end
      end
      S_BIAS: begin
        if (cnt == BIAS_LAST) begin
          state_n = S_MAC;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_MAC: begin
        if (cnt == MAC_LAST) begin
          state_n = S_DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_n = S_EMIT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_EMIT: begin
        if (k == K_LAST) begin
          state_n = S_FIN;
        end else begin
          state_n = S_BIAS;
          k_n     = k + 1'b1;
          cnt_n   = '0;
        end
      end
      S_FIN: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      k           <= '0;
      acc         <= '0;
      max_q       <= '0;
      best        <= '0;
      act_addr    <= '0;
      wgt_addr    <= '0;
      bias_addr   <= '0;
      logit_out   <= '0;
      logit_idx   <= '0;
      logit_valid <= 1'b0;
      class_id    <= '0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      k           <= k_n;
      logit_valid <= 1'b0;
      done        <= 1'b0;

      // Addresses are loaded from next-state values so they are
      // presented during the cycle that issues them.
      if (state_n == S_BIAS && cnt_n == '0) begin
        bias_addr <= k_n;
      end
      if (state_n == S_MAC) begin
        act_addr <= cnt_n;
        wgt_addr <= WGT_ADDR_WIDTH'(32'(k_n) * IN_LEN + 32'(cnt_n));
      end

      if (state == S_BIAS && cnt == BIAS_LAST) begin
        acc <= ACC_WIDTH'($signed(bias_data));
      end else if (mac_valid) begin
        acc <= acc + mac_prod;
      end

      if (state == S_EMIT) begin
        logit_out   <= acc;
        logit_idx   <= k;
        logit_valid <= 1'b1;
        if (k == '0 || $signed(acc) > $signed(max_q)) begin
          max_q <= acc;
          best  <= k;
        end
      end

      if (state == S_FIN) begin
        class_id <= best;
        done     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fc_classifier.sv
// Self-checking bench for fc_classifier with small vectors.
// Behavioural 2-cycle memories and a dot-product/argmax reference model.
module tb_fc_classifier;

  localparam int DW  = 8;
  localparam int L   = 4;
  localparam int N   = 3;
  localparam int BW  = 32;
  localparam int AW  = 32;
  localparam int AAW = 13;
  localparam int WAW = 16;
  localparam int CW  = 3;
  localparam int DONE_CYC = N * (L + 6) + 2;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           busy;
  logic [AAW-1:0] act_addr;
  logic [DW-1:0]  act_data;
  logic [WAW-1:0] wgt_addr;
  logic [DW-1:0]  wgt_data;
  logic [CW-1:0]  bias_addr;
  logic [BW-1:0]  bias_data;
  logic           logit_valid;
  logic [CW-1:0]  logit_idx;
  logic [AW-1:0]  logit_out;
  logic [CW-1:0]  class_id;
  logic           done;

  fc_classifier #(
    .DATA_WIDTH     (DW),
    .IN_LEN         (L),
    .NUM_CLASSES    (N),
    .BIAS_WIDTH     (BW),
    .ACC_WIDTH      (AW),
    .ACT_ADDR_WIDTH (AAW),
    .WGT_ADDR_WIDTH (WAW),
    .CLS_WIDTH      (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .act_addr    (act_addr),
    .act_data    (act_data),
    .wgt_addr    (wgt_addr),
    .wgt_data    (wgt_data),
    .bias_addr   (bias_addr),
    .bias_data   (bias_data),
    .logit_valid (logit_valid),
    .logit_idx   (logit_idx),
    .logit_out   (logit_out),
    .class_id    (class_id),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] act_mem [L];
  logic [DW-1:0] wgt_mem [N*L];
  logic [BW-1:0] bias_mem [N];

  logic [AAW-1:0] a1;
  logic [WAW-1:0] w1;
  logic [CW-1:0]  b1;

  always @(posedge clk) begin
    a1        <= act_addr;
    w1        <= wgt_addr;
    b1        <= bias_addr;
    act_data  <= act_mem[a1];
    wgt_data  <= wgt_mem[w1];
    bias_data <= bias_mem[b1];
  end

  int passed;
  int total;

  int            dcyc;
  int            nlog;
  logic          done_after;
  logic          busy1;
  logic          busy_at_done;
  logic [AW-1:0] got_logit [8];
  logic [CW-1:0] got_idx [8];
  logic [CW-1:0] cls;
  int            exp_logit [N];
  int            exp_cls;

  function automatic void compute_ref();
    int s;
    for (int k = 0; k < N; k++) begin
      s = $signed(bias_mem[k]);
      for (int i = 0; i < L; i++) begin
        s = s + $signed(act_mem[i]) * $signed(wgt_mem[k*L+i]);
      end
      exp_logit[k] = s;
    end
    exp_cls = 0;
    for (int k = 1; k < N; k++) begin
      if (exp_logit[k] > exp_logit[exp_cls]) exp_cls = k;
    end
  endfunction

  task automatic classify(input bit hold);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    dcyc = -1;
    nlog = 0;
    busy1 = 1'b0;
    busy_at_done = 1'b1;
    cls = '0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) busy1 = busy;
      if (logit_valid) begin
        if (nlog < 8) begin
          got_logit[nlog] = logit_out;
          got_idx[nlog]   = logit_idx;
        end
        nlog++;
      end
      if (done) begin
        dcyc = c;
        cls = class_id;
        busy_at_done = busy;
        break;
      end
    end
    @(negedge clk);
    done_after = done;
  endtask

  task automatic load_basic();
    act_mem[0] = 8'd1; act_mem[1] = 8'd2;
    act_mem[2] = 8'd3; act_mem[3] = 8'd4;
    for (int i = 0; i < L; i++) wgt_mem[i] = 8'd1;
    for (int i = 0; i < L; i++) wgt_mem[L+i] = 8'd0;
    wgt_mem[L+3] = 8'd2;
    for (int i = 0; i < L; i++) wgt_mem[2*L+i] = 8'd0;
    wgt_mem[2*L] = 8'hFF;
    bias_mem[0] = 32'd0;
    bias_mem[1] = 32'd5;
    bias_mem[2] = 32'd100;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    load_basic();
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, logit_valid} !== 3'b000 || logit_out !== '0 ||
        class_id !== '0 || logit_idx !== '0 || act_addr !== '0 ||
        wgt_addr !== '0 || bias_addr !== '0) begin
      $display("FAIL reset_outputs busy=%b done=%b lv=%b logit=%0d cls=%0d aa=%0d wa=%0d ba=%0d required all 0",
               busy, done, logit_valid, logit_out, class_id, act_addr, wgt_addr, bias_addr);
    end else passed++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL idle_after_reset busy=%b done=%b required 0 0", busy, done);
    end else passed++;
  endtask

  task automatic test_basic();
    int want [N];
    want[0] = 10; want[1] = 13; want[2] = 99;
    load_basic();
    classify(1'b0);
    total++;
    if (busy1 !== 1'b1) begin
      $display("FAIL basic_busy got=%b required 1", busy1);
    end else passed++;
    total++;
    if (dcyc !== DONE_CYC) begin
      $display("FAIL basic_done_cycle got=%0d required %0d", dcyc, DONE_CYC);
    end else passed++;
    total++;
    if (nlog !== N) begin
      $display("FAIL basic_logit_count got=%0d required %0d", nlog, N);
    end else passed++;
    for (int k = 0; k < N; k++) begin
      total++;
      if (got_logit[k] !== want[k] || got_idx[k] !== CW'(k)) begin
        $display("FAIL basic_logit%0d got=%0d idx=%0d required %0d idx=%0d",
                 k, $signed(got_logit[k]), got_idx[k], want[k], k);
      end else passed++;
    end
    total++;
    if (cls !== 3'd2) begin
      $display("FAIL basic_class got=%0d required 2", cls);
    end else passed++;
    total++;
    if (done_after !== 1'b0 || busy_at_done !== 1'b0) begin
      $display("FAIL basic_done_pulse done_next=%b busy_at_done=%b required 0 0",
               done_after, busy_at_done);
    end else passed++;
    repeat (5) @(negedge clk);
    total++;
    if (class_id !== 3'd2 || logit_out !== 32'd99) begin
      $display("FAIL basic_hold cls=%0d logit=%0d required 2 99", class_id, logit_out);
    end else passed++;
  endtask

  task automatic test_negatives();
    for (int i = 0; i < L; i++) act_mem[i] = 8'h80;
    for (int i = 0; i < N*L; i++) wgt_mem[i] = 8'h00;
    for (int i = 0; i < L; i++) wgt_mem[i] = 8'h80;
    for (int k = 0; k < N; k++) bias_mem[k] = '0;
    classify(1'b0);
    total++;
    if (got_logit[0] !== 32'd65536 || cls !== 3'd0) begin
      $display("FAIL neg_logit0 got=%0d cls=%0d required 65536 0",
               $signed(got_logit[0]), cls);
    end else passed++;
  endtask

  task automatic test_tie();
    for (int i = 0; i < N*L; i++) wgt_mem[i] = 8'h00;
    bias_mem[0] = 32'd7; bias_mem[1] = 32'd7; bias_mem[2] = 32'd3;
    classify(1'b0);
    total++;
    if (cls !== 3'd0 || got_logit[1] !== 32'd7) begin
      $display("FAIL tie_class got=%0d logit1=%0d required 0 7", cls, $signed(got_logit[1]));
    end else passed++;
  endtask

  task automatic test_all_negative();
    for (int i = 0; i < N*L; i++) wgt_mem[i] = 8'h00;
    bias_mem[0] = -32'sd10; bias_mem[1] = -32'sd3; bias_mem[2] = -32'sd20;
    classify(1'b0);
    total++;
    if (cls !== 3'd1) begin
      $display("FAIL allneg_class got=%0d required 1", cls);
    end else passed++;
    total++;
    if (got_logit[2] !== 32'hFFFF_FFEC) begin
      $display("FAIL allneg_logit2 got=%0d required -20", $signed(got_logit[2]));
    end else passed++;
  endtask

  task automatic test_abort();
    int pulses;
    load_basic();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(negedge clk);
    total++;
    if (busy !== 1'b1 || logit_out !== 32'd10) begin
      $display("FAIL abort_pre busy=%b logit=%0d required 1 10", busy, logit_out);
    end else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, logit_valid} !== 3'b000 || logit_out !== '0 ||
        class_id !== '0 || logit_idx !== '0 || act_addr !== '0 ||
        wgt_addr !== '0 || bias_addr !== '0) begin
      $display("FAIL abort_clear busy=%b done=%b lv=%b logit=%0d cls=%0d aa=%0d wa=%0d required all 0",
               busy, done, logit_valid, logit_out, class_id, act_addr, wgt_addr);
    end else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (done || logit_valid || busy) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      $display("FAIL abort_quiet got=%0d active cycles required 0", pulses);
    end else passed++;
    classify(1'b0);
    total++;
    if (dcyc !== DONE_CYC || cls !== 3'd2 || got_logit[0] !== 32'd10 ||
        got_logit[1] !== 32'd13 || got_logit[2] !== 32'd99) begin
      $display("FAIL abort_restart dcyc=%0d cls=%0d l0=%0d l1=%0d l2=%0d required %0d 2 10 13 99",
               dcyc, cls, got_logit[0], got_logit[1], got_logit[2], DONE_CYC);
    end else passed++;
  endtask

  task automatic test_start_busy();
    int d2;
    logic b2;
    load_basic();
    classify(1'b1);
    total++;
    if (dcyc !== DONE_CYC || cls !== 3'd2) begin
      $display("FAIL hold_first dcyc=%0d cls=%0d required %0d 2", dcyc, cls, DONE_CYC);
    end else passed++;
    total++;
    if (done_after !== 1'b0 || busy_at_done !== 1'b0) begin
      $display("FAIL hold_done_cycle done_next=%b busy_at_done=%b required 0 0",
               done_after, busy_at_done);
    end else passed++;
    d2 = -1;
    b2 = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) b2 = busy;
      if (done) begin
        d2 = c;
        break;
      end
    end
    start = 1'b0;
    total++;
    if (b2 !== 1'b1 || d2 !== DONE_CYC) begin
      $display("FAIL hold_second busy=%b dcyc=%0d required 1 %0d", b2, d2, DONE_CYC);
    end else passed++;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      $display("FAIL hold_stop busy=%b required 0", busy);
    end else passed++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < L; i++) act_mem[i] = DW'($urandom);
      for (int i = 0; i < N*L; i++) wgt_mem[i] = DW'($urandom);
      for (int k = 0; k < N; k++) begin
        if (it % 2 == 0) bias_mem[k] = $urandom;
        else bias_mem[k] = BW'($urandom_range(0, 400)) - BW'(200);
      end
      compute_ref();
      classify(1'b0);
      total++;
      if (dcyc !== DONE_CYC || nlog !== N) begin
        $display("FAIL rand%0d_timing dcyc=%0d nlog=%0d required %0d %0d",
                 it, dcyc, nlog, DONE_CYC, N);
      end else passed++;
      for (int k = 0; k < N; k++) begin
        total++;
        if ($signed(got_logit[k]) !== exp_logit[k] || got_idx[k] !== CW'(k)) begin
          $display("FAIL rand%0d_logit%0d got=%0d idx=%0d required %0d idx=%0d",
                   it, k, $signed(got_logit[k]), got_idx[k], exp_logit[k], k);
        end else passed++;
      end
      total++;
      if (cls !== CW'(exp_cls)) begin
        $display("FAIL rand%0d_class got=%0d required %0d", it, cls, exp_cls);
      end else passed++;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_basic();
    test_negatives();
    test_tie();
    test_all_negative();
    test_abort();
    test_start_busy();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
